// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the channel scan controller.
// No logic of its own; constants and a pure function only.
// No flow control.
package mux_scan_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    localparam int CH_NUM = 4;
    localparam int CH_W   = 2;

    // Lowest enabled channel whose index is >= from.
    // Result is {found, channel}; found=0 means no such channel remains.
    function automatic logic [CH_W:0] next_enabled_ch(input logic [CH_NUM-1:0] mask,
                                                      input logic [CH_W:0]     from);
        logic [CH_W:0] res;
        res = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                res = {1'b1, CH_W'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wrap marks the last cycle.
// Latency: wrap is combinational from the count register and en.
// No flow control; clr overrides en.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Count up while enabled, fold back to zero on the last dwell cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel scan controller: snapshots din, then steps valid across channels with flag high.
// Latency: all outputs registered; start/stop take effect on the next cycle.
// No backpressure; optional channel mask via MUX_SCAN_MASK_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            cont,
    input  logic [3:0]      din,
`ifdef MUX_SCAN_MASK_EN
    input  logic [3:0]      mask,
`endif
    output logic [3:0]      data,
    output logic [CH_W-1:0] valid,
    output logic            flag,
    output logic            frame_done
);

    state_t            state, state_nxt;
    logic [3:0]        data_nxt;
    logic [CH_W-1:0]   valid_nxt;
    logic              flag_nxt;
    logic              fd_nxt;
    logic              wrap;

    // Channel selection helpers: capture channel, last-channel test, advance.
    logic              cap_ok;
    logic [CH_W-1:0]   cap_ch;
    logic              last_ch;
    logic [CH_W-1:0]   adv_ch;

`ifdef MUX_SCAN_MASK_EN
    logic [CH_NUM-1:0] mask_q, mask_nxt;
    logic [CH_W:0]     first_in;
    logic [CH_W:0]     next_cur;

    assign first_in = next_enabled_ch(mask, '0);
    assign next_cur = next_enabled_ch(mask_q, {1'b0, valid} + (CH_W+1)'(1));
    assign cap_ok   = first_in[CH_W];
    assign cap_ch   = first_in[CH_W-1:0];
    assign last_ch  = !next_cur[CH_W];
    assign adv_ch   = next_cur[CH_W-1:0];
`else
    assign cap_ok   = 1'b1;
    assign cap_ch   = '0;
    assign last_ch  = (valid == CH_W'(CH_NUM - 1));
    assign adv_ch   = valid + CH_W'(1);
`endif

    // Counter runs only while scanning; idle and stop hold it at zero.
    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == S_IDLE) || stop),
        .en   (state == S_SCAN),
        .wrap (wrap)
    );

    // Next-state and next-output logic; stop outranks frame end and recapture.
    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        valid_nxt = valid;
        flag_nxt  = flag;
        fd_nxt    = 1'b0;
`ifdef MUX_SCAN_MASK_EN
        mask_nxt  = mask_q;
`endif
        case (state)
            S_IDLE: begin
                flag_nxt  = 1'b0;
                valid_nxt = '0;
                if (start && !stop && cap_ok) begin
                    data_nxt  = din;
                    valid_nxt = cap_ch;
                    flag_nxt  = 1'b1;
                    state_nxt = S_SCAN;
`ifdef MUX_SCAN_MASK_EN
                    mask_nxt  = mask;
`endif
                end
            end
            S_SCAN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    flag_nxt  = 1'b0;
                    valid_nxt = '0;
                end else if (wrap) begin
                    if (last_ch) begin
                        fd_nxt = 1'b1;
                        if (cont && cap_ok) begin
                            data_nxt  = din;
                            valid_nxt = cap_ch;
`ifdef MUX_SCAN_MASK_EN
                            mask_nxt  = mask;
`endif
                        end else begin
                            state_nxt = S_IDLE;
                            flag_nxt  = 1'b0;
                            valid_nxt = '0;
                        end
                    end else begin
                        valid_nxt = adv_ch;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                flag_nxt  = 1'b0;
                valid_nxt = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            data       <= '0;
            valid      <= '0;
            flag       <= 1'b0;
            frame_done <= 1'b0;
`ifdef MUX_SCAN_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            data       <= data_nxt;
            valid      <= valid_nxt;
            flag       <= flag_nxt;
            frame_done <= fd_nxt;
`ifdef MUX_SCAN_MASK_EN
            mask_q     <= mask_nxt;
`endif
        end
    end

endmodule
